// File: rtl/pcm_serial_tx.sv
// PCM serializer: takes CHANNELS x DATA_W frames over valid/ready and shifts them out with a
// generated bit clock and channel-select clock, streaming back-to-back frames without gaps.
module pcm_serial_tx #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned BCLK_DIV  = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       enable_i,
    input  logic [CHANNELS*DATA_W-1:0] d_in_i,
    input  logic                       d_valid_i,
    output logic                       d_ready_o,
    output logic                       bclk_o,
    output logic                       lrclk_o,
    output logic                       d_out_o,
    output logic                       done_o,
    output logic                       act_o
);

    localparam int unsigned TotW = CHANNELS * DATA_W;
    localparam int unsigned DivW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned ChW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [DivW-1:0] DivMax = DivW'(BCLK_DIV - 1);
    localparam logic [BitW-1:0] BitMax = BitW'(DATA_W - 1);
    localparam logic [ChW-1:0]  ChMax  = ChW'(CHANNELS - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [ChW-1:0]    ch_q, ch_d;
    logic [TotW-1:0]   sr_q, sr_d;
    logic              bclk_q, bclk_d;
    logic              lrclk_q, lrclk_d;
    logic              d_out_q, d_out_d;
    logic              done_q, done_d;
    logic              act_q, act_d;

    logic [TotW-1:0]   frame_seq;
    logic              div_wrap;
    logic              last_bit;
    logic              fall_edge;
    logic              ready;
    logic              accept;

    // Reorder the frame so the transmit order is always "shift out the MSB":
    // channel slices stay in place, LSB-first mode mirrors each slice.
    always_comb begin
        frame_seq = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            for (int unsigned k = 0; k < DATA_W; k++) begin
                if (MSB_FIRST) begin
                    frame_seq[c*DATA_W + k] = d_in_i[c*DATA_W + k];
                end else begin
                    frame_seq[c*DATA_W + k] = d_in_i[c*DATA_W + DATA_W - 1 - k];
                end
            end
        end
    end

    assign div_wrap  = (div_q == DivMax);
    assign last_bit  = (bit_q == BitMax) && (ch_q == ChMax);
    assign fall_edge = (state_q == StShift) && div_wrap && bclk_q;

    // Ready only in idle or in the very last cycle of a frame so the next frame lands on the
    // final falling edge with no bclk gap.
    assign ready  = reset_ni && enable_i &&
                    ((state_q == StIdle) || (fall_edge && last_bit));
    assign accept = ready && d_valid_i;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        ch_d    = ch_q;
        sr_d    = sr_q;
        bclk_d  = bclk_q;
        lrclk_d = lrclk_q;
        d_out_d = d_out_q;
        done_d  = 1'b0;
        act_d   = act_q;

        unique case (state_q)
            StIdle: begin
                bclk_d  = 1'b0;
                lrclk_d = 1'b0;
                d_out_d = 1'b0;
                act_d   = 1'b0;
            end
            StShift: begin
                if (!div_wrap) begin
                    div_d = div_q + DivW'(1);
                end else begin
                    div_d  = '0;
                    bclk_d = ~bclk_q;
                    if (bclk_q) begin
                        if (last_bit) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                            bclk_d  = 1'b0;
                            lrclk_d = 1'b0;
                            d_out_d = 1'b0;
                            act_d   = 1'b0;
                        end else begin
                            if (bit_q == BitMax) begin
                                bit_d = '0;
                                ch_d  = ch_q + ChW'(1);
                            end else begin
                                bit_d = bit_q + BitW'(1);
                            end
                            lrclk_d = ch_d[0];
                            d_out_d = sr_q[TotW-1];
                            sr_d    = sr_q << 1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A load overrides the idle/end-of-frame defaults above.
        if (accept) begin
            state_d = StShift;
            div_d   = '0;
            bit_d   = '0;
            ch_d    = '0;
            bclk_d  = 1'b0;
            lrclk_d = 1'b0;
            d_out_d = frame_seq[TotW-1];
            sr_d    = frame_seq << 1;
            act_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            ch_q    <= '0;
            sr_q    <= '0;
            bclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            d_out_q <= 1'b0;
            done_q  <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            ch_q    <= ch_d;
            sr_q    <= sr_d;
            bclk_q  <= bclk_d;
            lrclk_q <= lrclk_d;
            d_out_q <= d_out_d;
            done_q  <= done_d;
            act_q   <= act_d;
        end
    end

    assign d_ready_o = ready;
    assign bclk_o    = bclk_q;
    assign lrclk_o   = lrclk_q;
    assign d_out_o   = d_out_q;
    assign done_o    = done_q;
    assign act_o     = act_q;

endmodule

// File: tb/tb_pcm_serial_tx.sv
// Directed bench for pcm_serial_tx: default 2x16 instance plus an 8-bit mono LSB-first instance.
module tb_pcm_serial_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] d_in;
    logic        d_valid;
    logic        d_ready, bclk, lrclk, d_out, done, act;

    logic [7:0]  d8_in;
    logic        d8_valid;
    logic        d8_ready, bclk8, lrclk8, d_out8, done8, act8;

    int checks = 0;
    int errors = 0;

    logic s_bclk [0:1023];
    logic s_dout [0:1023];
    logic s_lr   [0:1023];
    logic s_done [0:1023];
    logic s_act  [0:1023];
    logic s_rdy  [0:1023];
    int   win_len;

    logic [127:0] cap, lrcap;
    int ncap, ndone, done_first, nact, nrdy, nrdy_frame, stab_err, bclk_err;

    always #5 clk = ~clk;

    pcm_serial_tx u_dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .enable_i (enable),
        .d_in_i   (d_in),
        .d_valid_i(d_valid),
        .d_ready_o(d_ready),
        .bclk_o   (bclk),
        .lrclk_o  (lrclk),
        .d_out_o  (d_out),
        .done_o   (done),
        .act_o    (act)
    );

    pcm_serial_tx #(
        .DATA_W   (8),
        .CHANNELS (1),
        .BCLK_DIV (1),
        .MSB_FIRST(1'b0)
    ) u_dut8 (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .enable_i (1'b1),
        .d_in_i   (d8_in),
        .d_valid_i(d8_valid),
        .d_ready_o(d8_ready),
        .bclk_o   (bclk8),
        .lrclk_o  (lrclk8),
        .d_out_o  (d_out8),
        .done_o   (done8),
        .act_o    (act8)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered #1 after the accept edge; k counts cycles since that edge.
    task automatic run_window(input int ncyc, input int drop_k, input int en_off_k,
                              input int rst_k, input logic [31:0] n0, input logic [31:0] n1);
        win_len = ncyc;
        for (int k = 0; k < ncyc; k++) begin
            s_bclk[k] = bclk;
            s_dout[k] = d_out;
            s_lr[k]   = lrclk;
            s_done[k] = done;
            s_act[k]  = act;
            s_rdy[k]  = d_ready;
            if (k == 0)        d_in = n0;
            if (k == 256)      d_in = n1;
            if (k == drop_k)   d_valid = 1'b0;
            if (k == en_off_k) enable = 1'b0;
            if (k == rst_k)    rst_n = 1'b0;
            if (k == rst_k + 1) rst_n = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic analyze(input int nk, input int half);
        cap = '0; lrcap = '0; ncap = 0; ndone = 0; done_first = -1; nact = 0;
        nrdy = 0; nrdy_frame = 0; stab_err = 0; bclk_err = 0;
        for (int k = 0; k < win_len; k++) begin
            if (k > 0 && s_bclk[k] && !s_bclk[k-1]) begin
                cap   = {cap[126:0], s_dout[k]};
                lrcap = {lrcap[126:0], s_lr[k]};
                ncap++;
            end
            if (k > 0 && s_bclk[k] && s_bclk[k-1] && (s_dout[k] != s_dout[k-1])) stab_err++;
            if (s_done[k]) begin
                ndone++;
                if (done_first < 0) done_first = k;
            end
            if (s_act[k]) nact++;
            if (s_rdy[k]) nrdy++;
            if (s_rdy[k] && k < nk - 1) nrdy_frame++;
            if (k < nk && s_bclk[k] != logic'((k / half) % 2)) bclk_err++;
        end
    endtask

    task automatic start_frame(input string tag, input logic [31:0] v);
        d_in    = v;
        d_valid = 1'b1;
        check(tag, d_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input string tag, input logic [7:0] v, input logic [7:0] exp_cap);
        logic [7:0] c8;
        int n8, d8_first, lr8, b8_err;
        c8 = '0; n8 = 0; d8_first = -1; lr8 = 0; b8_err = 0;
        d8_in    = v;
        d8_valid = 1'b1;
        check({tag, "_rdy"}, d8_ready, 1'b1);
        @(posedge clk);
        #1;
        check({tag, "_first"}, d_out8, v[0]);
        for (int k = 0; k < 40; k++) begin
            s_bclk[k] = bclk8;
            if (k > 0 && bclk8 && !s_bclk[k-1]) begin
                c8 = {c8[6:0], d_out8};
                n8++;
            end
            if (lrclk8) lr8++;
            if (done8 && d8_first < 0) d8_first = k;
            if (k < 16 && bclk8 != logic'(k % 2)) b8_err++;
            if (k == 0) d8_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        check({tag, "_bits"}, {n8[7:0], c8}, {8'd8, exp_cap});
        check({tag, "_done"}, d8_first, 16);
        check({tag, "_lrclk"}, lr8, 0);
        check({tag, "_bclk"}, b8_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        d_valid  = 1'b1;
        d_in     = 32'hB4C0_8001;
        d8_valid = 1'b0;
        d8_in    = '0;

        // Reset held with valid/enable asserted: everything low.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("reset_outs", {d_ready, bclk, lrclk, d_out, done, act}, 6'b0);
        end
        d_valid = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        check("idle_outs", {d_ready, bclk, lrclk, d_out, done, act}, 6'b100000);

        // Single frame, default parameters.
        start_frame("t2_rdy", 32'hB4C0_8001);
        check("t2_first_bit", d_out, 1'b1);
        run_window(300, 0, -1, -1, 32'h0, 32'h0);
        analyze(256, 4);
        check("t2_bits", {ncap[7:0], cap[31:0]}, {8'd32, 32'hB4C0_8001});
        check("t2_lrclk", lrcap[31:0], 32'h0000_FFFF);
        check("t2_done", {ndone[7:0], done_first[15:0]}, {8'd1, 16'd256});
        check("t2_act", nact, 256);
        check("t2_bclk", bclk_err, 0);
        check("t2_stable", stab_err, 0);
        check("t2_idle_after", {s_bclk[260], s_dout[260], s_act[260]}, 3'b000);

        // Three back-to-back frames.
        start_frame("t3_rdy", 32'h1234_5678);
        run_window(800, 512, -1, -1, 32'hFFFF_0000, 32'h8001_7FFE);
        analyze(768, 4);
        check("t3_bits", {ncap[7:0], cap[95:0]},
              {8'd96, 32'h1234_5678, 32'hFFFF_0000, 32'h8001_7FFE});
        check("t3_done", {ndone[7:0], s_done[256], s_done[512], s_done[768]},
              {8'd3, 3'b111});
        check("t3_rdy_pulses", {nrdy_frame[7:0], s_rdy[255], s_rdy[511], s_rdy[767]},
              {8'd2, 3'b111});
        check("t3_bclk", bclk_err, 0);
        check("t3_act", nact, 768);
        check("t3_stable", stab_err, 0);

        // Enable dropped during bit 5: frame finishes, then idle and not ready.
        start_frame("t4_rdy", 32'hCAFE_F00D);
        run_window(300, 0, 42, -1, 32'h0, 32'h0);
        analyze(256, 4);
        check("t4_bits", cap[31:0], 32'hCAFE_F00D);
        check("t4_done", {ndone[7:0], done_first[15:0]}, {8'd1, 16'd256});
        check("t4_act", nact, 256);
        check("t4_no_ready", nrdy, 0);
        enable = 1'b1;
        @(posedge clk);
        #1;

        // One-cycle reset during bit 7 abandons the frame.
        start_frame("t5_rdy", 32'hFFFF_FFFF);
        run_window(120, 0, -1, 57, 32'h0, 32'h0);
        analyze(0, 4);
        check("t5_pre_reset", {s_act[57], s_dout[57]}, 2'b11);
        check("t5_reset_outs",
              {s_rdy[58], s_bclk[58], s_lr[58], s_dout[58], s_done[58], s_act[58]}, 6'b0);
        check("t5_no_done", ndone, 0);
        start_frame("t5_restart_rdy", 32'h9000_0001);
        check("t5_restart_first", d_out, 1'b1);
        run_window(300, 0, -1, -1, 32'h0, 32'h0);
        analyze(256, 4);
        check("t5_restart_bits", {ncap[7:0], cap[31:0]}, {8'd32, 32'h9000_0001});
        check("t5_restart_done", done_first, 256);

        // 8-bit mono, LSB first, divide-by-one.
        run8("t6a", 8'h01, 8'h80);
        run8("t6b", 8'hB4, 8'h2D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
